// File: rtl/fetch_stage.sv
// Instruction fetch front end: one outstanding memory request, a one-entry skid buffer
// ahead of the decode registers, and redirect flushing. dbg_state_o: 0=ISSUE 1=WAIT 2=DROP.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_ready,
    input  logic        im_rvalid,
    input  logic [31:0] im_rdata,
    input  logic        ex_redirect,
    input  logic [31:0] ex_target,
    input  logic        d_stall,
    output logic [31:0] D_instruction,
    output logic [31:0] D_pc,
    output logic        D_valid,
    output logic [1:0]  dbg_state_o
);

    // Handshakes: a request transfers on a cycle with im_req && im_ready; im_addr is
    // stable while im_req waits. A response is one im_rvalid cycle, never stalled.
    // Decode takes D whenever D is empty or d_stall is low.

    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        ST_ISSUE = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DROP  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic        d_valid_q, d_valid_d;
    logic [31:0] d_instr_q, d_instr_d;
    logic [31:0] d_pc_q, d_pc_d;

    logic        d_accept;
    logic        rsp_fire;
    logic        req_w;

    always_comb begin
        d_accept = !d_valid_q || !d_stall;
        rsp_fire = (state_q == ST_WAIT) && im_rvalid;
        req_w    = (state_q == ST_ISSUE) && !skid_valid_q && !ex_redirect && !rst;
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_pc_d     = req_pc_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        d_valid_d    = d_valid_q;
        d_instr_d    = d_instr_q;
        d_pc_d       = d_pc_q;

        if (ex_redirect) begin
            // Flush wins over stall; an in-flight response must still be swallowed.
            pc_d         = ex_target & WORD_MASK;
            d_valid_d    = 1'b0;
            d_instr_d    = NOP;
            skid_valid_d = 1'b0;
            case (state_q)
                ST_WAIT:  state_d = im_rvalid ? ST_ISSUE : ST_DROP;
                ST_DROP:  state_d = im_rvalid ? ST_ISSUE : ST_DROP;
                default:  state_d = ST_ISSUE;
            endcase
        end else begin
            case (state_q)
                ST_ISSUE: begin
                    if (req_w && im_ready) begin
                        state_d  = ST_WAIT;
                        req_pc_d = pc_q;
                        pc_d     = pc_q + 32'd4;
                    end
                end
                ST_WAIT: begin
                    if (im_rvalid) state_d = ST_ISSUE;
                end
                ST_DROP: begin
                    if (im_rvalid) state_d = ST_ISSUE;
                end
                default: state_d = ST_ISSUE;
            endcase

            if (d_accept) begin
                if (skid_valid_q) begin
                    d_valid_d    = 1'b1;
                    d_instr_d    = skid_instr_q;
                    d_pc_d       = skid_pc_q;
                    skid_valid_d = rsp_fire;
                    if (rsp_fire) begin
                        skid_instr_d = im_rdata;
                        skid_pc_d    = req_pc_q;
                    end
                end else if (rsp_fire) begin
                    d_valid_d = 1'b1;
                    d_instr_d = im_rdata;
                    d_pc_d    = req_pc_q;
                end else begin
                    d_valid_d = 1'b0;
                    d_instr_d = NOP;
                end
            end else if (rsp_fire) begin
                skid_valid_d = 1'b1;
                skid_instr_d = im_rdata;
                skid_pc_d    = req_pc_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_ISSUE;
            pc_q         <= RESET_PC & WORD_MASK;
            req_pc_q     <= 32'd0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= NOP;
            skid_pc_q    <= 32'd0;
            d_valid_q    <= 1'b0;
            d_instr_q    <= NOP;
            d_pc_q       <= 32'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_pc_q     <= req_pc_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            d_valid_q    <= d_valid_d;
            d_instr_q    <= d_instr_d;
            d_pc_q       <= d_pc_d;
        end
    end

    assign im_req        = req_w;
    assign im_addr       = pc_q;
    assign D_instruction = d_instr_q;
    assign D_pc          = d_pc_q;
    assign D_valid       = d_valid_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: the bench plays instruction memory cycle by cycle and
// checks the decode registers against a queue of expected {pc, instruction} pairs.
module tb_fetch_stage;

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [1:0]  S_ISSUE  = 2'd0;
    localparam logic [1:0]  S_WAIT   = 2'd1;
    localparam logic [1:0]  S_DROP   = 2'd2;

    logic        clk;
    logic        rst;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ready;
    logic        im_rvalid;
    logic [31:0] im_rdata;
    logic        ex_redirect;
    logic [31:0] ex_target;
    logic        d_stall;
    logic [31:0] D_instruction;
    logic [31:0] D_pc;
    logic        D_valid;
    logic [1:0]  dbg_state_o;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    fetch_stage #(.RESET_PC(RESET_PC), .NOP(NOP)) dut (
        .clk          (clk),
        .rst          (rst),
        .im_req       (im_req),
        .im_addr      (im_addr),
        .im_ready     (im_ready),
        .im_rvalid    (im_rvalid),
        .im_rdata     (im_rdata),
        .ex_redirect  (ex_redirect),
        .ex_target    (ex_target),
        .d_stall      (d_stall),
        .D_instruction(D_instruction),
        .D_pc         (D_pc),
        .D_valid      (D_valid),
        .dbg_state_o  (dbg_state_o)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0003;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // drivers
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_accept(input logic [31:0] addr);
        chk("req_valid", {63'd0, im_req}, 64'd1);
        chk("req_addr", {32'd0, im_addr}, {32'd0, addr});
        im_ready = 1'b1;
        step();
        im_ready = 1'b0;
        #1;
        chk("state_wait", {62'd0, dbg_state_o}, {62'd0, S_WAIT});
    endtask

    task automatic respond(input logic [31:0] data);
        im_rvalid = 1'b1;
        im_rdata  = data;
        step();
        im_rvalid = 1'b0;
        im_rdata  = 32'd0;
        #1;
    endtask

    // scoreboard
    task automatic pop_check();
        logic [63:0] e;
        if (exp_q.size() == 0) begin
            chk("sb_underflow", 64'd0, 64'd1);
        end else begin
            e = exp_q.pop_front();
            chk("d_valid", {63'd0, D_valid}, 64'd1);
            chk("d_pc", {32'd0, D_pc}, {32'd0, e[63:32]});
            chk("d_instr", {32'd0, D_instruction}, {32'd0, e[31:0]});
        end
    endtask

    task automatic fetch(input logic [31:0] addr);
        issue_accept(addr);
        exp_q.push_back({addr, instr_of(addr)});
        respond(instr_of(addr));
        pop_check();
    endtask

    initial begin
        logic [31:0] addr;
        int n;
        rst = 1'b1; im_ready = 1'b0; im_rvalid = 1'b0; im_rdata = 32'd0;
        ex_redirect = 1'b0; ex_target = 32'd0; d_stall = 1'b0;

        // reset values
        step();
        step();
        chk("rst_req", {63'd0, im_req}, 64'd0);
        chk("rst_dvalid", {63'd0, D_valid}, 64'd0);
        chk("rst_dinstr", {32'd0, D_instruction}, {32'd0, NOP});
        chk("rst_dpc", {32'd0, D_pc}, 64'd0);
        chk("rst_state", {62'd0, dbg_state_o}, {62'd0, S_ISSUE});
        rst = 1'b0;
        #1;

        // back-to-back fetches 0,4,8 with 1-cycle latency
        fetch(32'h0);
        fetch(32'h4);
        issue_accept(32'h8);
        chk("bubble_dvalid", {63'd0, D_valid}, 64'd0);
        chk("bubble_dinstr", {32'd0, D_instruction}, {32'd0, NOP});
        chk("bubble_dpc_hold", {32'd0, D_pc}, 64'h4);
        exp_q.push_back({32'h8, instr_of(32'h8)});
        respond(instr_of(32'h8));
        pop_check();

        // stall: response goes to skid, requests stop until it drains
        d_stall = 1'b1;
        issue_accept(32'hC);
        chk("stall_hold_pc", {32'd0, D_pc}, 64'h8);
        exp_q.push_back({32'hC, 32'h0050_0093});
        respond(32'h0050_0093);
        chk("skid_req_off", {63'd0, im_req}, 64'd0);
        chk("skid_state", {62'd0, dbg_state_o}, {62'd0, S_ISSUE});
        chk("skid_hold_pc", {32'd0, D_pc}, 64'h8);
        step();
        chk("skid_req_off2", {63'd0, im_req}, 64'd0);
        d_stall = 1'b0;
        #1;
        chk("skid_req_off3", {63'd0, im_req}, 64'd0);
        step();
        pop_check();
        chk("resume_req", {63'd0, im_req}, 64'd1);
        chk("resume_addr", {32'd0, im_addr}, 64'h10);

        // redirect during WAIT overrides stall, drops the response
        d_stall = 1'b1;
        issue_accept(32'h10);
        ex_redirect = 1'b1;
        ex_target = 32'h0000_1002;
        step();
        ex_redirect = 1'b0;
        d_stall = 1'b0;
        #1;
        chk("redir_state_drop", {62'd0, dbg_state_o}, {62'd0, S_DROP});
        chk("redir_dvalid", {63'd0, D_valid}, 64'd0);
        chk("redir_dinstr", {32'd0, D_instruction}, {32'd0, NOP});
        chk("drop_req_off", {63'd0, im_req}, 64'd0);
        respond(32'hDEAD_BEEF);
        chk("drop_no_capture", {63'd0, D_valid}, 64'd0);
        chk("drop_to_issue", {62'd0, dbg_state_o}, {62'd0, S_ISSUE});
        chk("redir_addr", {32'd0, im_addr}, 64'h1000);

        // further redirects while in DROP
        issue_accept(32'h1000);
        ex_redirect = 1'b1;
        ex_target = 32'h0000_2000;
        step();
        chk("drop_stay1", {62'd0, dbg_state_o}, {62'd0, S_DROP});
        ex_target = 32'h0000_3000;
        step();
        ex_redirect = 1'b0;
        #1;
        chk("drop_stay2", {62'd0, dbg_state_o}, {62'd0, S_DROP});
        respond(32'hBAD0_0001);
        chk("drop2_addr", {32'd0, im_addr}, 64'h3000);
        chk("drop2_dvalid", {63'd0, D_valid}, 64'd0);

        // redirect coincident with response
        issue_accept(32'h3000);
        ex_redirect = 1'b1;
        ex_target = 32'h0000_4000;
        im_rvalid = 1'b1;
        im_rdata = 32'h1234_5678;
        step();
        ex_redirect = 1'b0;
        im_rvalid = 1'b0;
        #1;
        chk("coinc_state", {62'd0, dbg_state_o}, {62'd0, S_ISSUE});
        chk("coinc_dvalid", {63'd0, D_valid}, 64'd0);
        fetch(32'h4000);

        // pc wrap at top of address space
        ex_redirect = 1'b1;
        ex_target = 32'hFFFF_FFFE;
        #1;
        chk("redir_req_off", {63'd0, im_req}, 64'd0);
        step();
        ex_redirect = 1'b0;
        #1;
        fetch(32'hFFFF_FFFC);
        chk("wrap_addr", {32'd0, im_addr}, 64'h0);

        // reset with skid full and stall held
        d_stall = 1'b1;
        issue_accept(32'h0);
        respond(32'hCAFE_0001);
        chk("pre_rst_skid", {63'd0, im_req}, 64'd0);
        rst = 1'b1;
        step();
        chk("rst2_dvalid", {63'd0, D_valid}, 64'd0);
        chk("rst2_dinstr", {32'd0, D_instruction}, {32'd0, NOP});
        chk("rst2_dpc", {32'd0, D_pc}, 64'd0);
        chk("rst2_state", {62'd0, dbg_state_o}, {62'd0, S_ISSUE});
        chk("rst2_req", {63'd0, im_req}, 64'd0);
        rst = 1'b0;
        d_stall = 1'b0;
        #1;
        chk("rst2_rel_req", {63'd0, im_req}, 64'd1);
        chk("rst2_rel_addr", {32'd0, im_addr}, {32'd0, RESET_PC});

        // reset mid-WAIT, stale response arrives in ISSUE
        issue_accept(32'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        im_rvalid = 1'b1;
        im_rdata = 32'hBEEF_0002;
        step();
        im_rvalid = 1'b0;
        #1;
        chk("stale_dvalid", {63'd0, D_valid}, 64'd0);
        chk("stale_state", {62'd0, dbg_state_o}, {62'd0, S_ISSUE});
        chk("stale_addr", {32'd0, im_addr}, 64'h0);

        // randomized ready delay and response latency
        addr = 32'h0;
        for (int i = 0; i < 6; i++) begin
            n = $urandom_range(0, 2);
            for (int k = 0; k < n; k++) begin
                step();
                chk("idle_req", {63'd0, im_req}, 64'd1);
            end
            issue_accept(addr);
            n = $urandom_range(0, 3);
            for (int k = 0; k < n; k++) begin
                step();
                chk("wait_hold", {62'd0, dbg_state_o}, {62'd0, S_WAIT});
                chk("wait_req_off", {63'd0, im_req}, 64'd0);
            end
            exp_q.push_back({addr, instr_of(addr)});
            respond(instr_of(addr));
            pop_check();
            addr = addr + 32'd4;
        end

        chk("sb_empty", {32'd0, 32'(exp_q.size())}, 64'd0);

        // report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 The block SHALL have parameter NOP, default 32'h0000_0013, the instruction presented when D_valid=0.
REQ-003 clk  in  1  rising-edge clock; sole clock domain.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 im_req  out  1  instruction-memory request valid.
REQ-006 im_addr  out  32  request word address; bits [1:0] always 00.
REQ-007 im_ready  in  1  memory accepts the request this cycle.
REQ-008 im_rvalid  in  1  response data valid; latency >=1 cycle after acceptance.
REQ-009 im_rdata  in  32  returned instruction word.
REQ-010 ex_redirect  in  1  one-cycle pulse: branch/jump taken, flush the front end.
REQ-011 ex_target  in  32  redirect target PC.
REQ-012 d_stall  in  1  decode cannot consume; hold the D registers.
REQ-013 D_instruction  out  32  registered instruction to decode and immediate extension.
REQ-014 D_pc  out  32  registered PC of D_instruction.
REQ-015 D_valid  out  1  D_instruction/D_pc hold a live instruction.

Function
REQ-016 The block SHALL implement FSM states ISSUE, WAIT and DROP, with at most one outstanding memory request.
REQ-017 In ISSUE: im_req=1 iff skid buffer empty and ex_redirect=0; im_addr=pc; on im_req&im_ready -> WAIT, pc<=pc+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
REQ-018 In WAIT: on im_rvalid, the {im_rdata, request PC} pair SHALL load D if D accepts, else the one-entry skid buffer; then -> ISSUE.
REQ-019 D accepts when D_valid=0 or d_stall=0; skid buffer contents have priority over a new response when loading D.
REQ-020 On D accept with no data available, D_valid<=0 and D_instruction<=NOP; D_pc holds.
REQ-021 When d_stall=1 and D_valid=1, D_instruction, D_pc and D_valid SHALL hold unchanged.
REQ-022 ex_redirect SHALL: set pc<={ex_target[31:2],2'b00}; clear D_valid; set D_instruction<=NOP; empty the skid buffer. It overrides d_stall.
REQ-023 On redirect in WAIT without same-cycle im_rvalid -> DROP; with same-cycle im_rvalid the data is discarded -> ISSUE.
REQ-024 In DROP: the next im_rvalid is discarded -> ISSUE; a further redirect updates pc and stays DROP.
REQ-025 Minimum latency: D_valid SHALL rise on the clock edge sampling im_rvalid=1, when D accepts.
REQ-026 im_rvalid in ISSUE SHALL be ignored (protocol error, no state change).
REQ-027 Priority per cycle: rst > ex_redirect > response/stall handling.

Reset
REQ-028 While rst=1 at a clock edge: pc<=RESET_PC, state<=ISSUE, skid empty, D_valid<=0, D_instruction<=NOP, D_pc<=0.
REQ-029 im_req SHALL be 0 in the cycle rst is asserted and SHALL rise in the first cycle after rst deasserts.
REQ-030 Reset mid-WAIT SHALL abandon the outstanding response; the block SHALL tolerate and discard one stale im_rvalid after reset (-> DROP behaviour is not required; the stale response SHALL simply not be captured when it arrives during ISSUE).

Verification
REQ-031 Reset release, im_ready=1, 1-cycle latency -> im_addr 0,4,8; D_pc 0,4,8 with D_valid=1, one instruction per two cycles.
REQ-032 d_stall=1 while response 0x00500093 arrives with D_valid=1 -> skid captures it, im_req=0; on stall release D shows it next cycle, im_req resumes.
REQ-033 ex_redirect target 0x0000_1002 during WAIT -> response discarded, D_valid=0, D_instruction=0x00000013, next im_addr=0x0000_1000.
REQ-034 Redirect coincident with im_rvalid -> no capture, state ISSUE, next im_addr=target.
REQ-035 pc=32'hFFFF_FFFC fetched -> next im_addr=32'h0000_0000.
REQ-036 rst asserted with skid full and d_stall=1 -> all outputs at reset values next cycle, im_addr=RESET_PC after release.
